// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts data grants that overtook a waiting instruction fetch; once the
// count reaches STARVE_LIMIT the next arbitration goes to the instruction side.
module arb_starve_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic i_req,
    input  logic grant_i,
    input  logic grant_d,
    output logic force_instr
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt;

    // Saturating count of data grants taken while an instruction fetch waited
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (grant_i) begin
            cnt <= '0;
        end else if (grant_d && i_req) begin
            if (cnt != LIMIT)
                cnt <= cnt + 1'b1;
        end else if (idle && !i_req) begin
            cnt <= '0;
        end
    end

    assign force_instr = (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a single backing
// memory. Data normally wins; a starvation counter guarantees fetch progress.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ack,
    output logic [XLEN-1:0] i_rdata,
    input  logic            d_req,
    input  logic            d_wr,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ack,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_wr,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            err
);

    state_t state;
    logic   force_instr;
    logic   idle;
    logic   grant_i;
    logic   grant_d;

    assign idle    = (state == IDLE);
    assign grant_i = idle && i_req && (!d_req || force_instr);
    assign grant_d = idle && d_req && !grant_i;

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk         (clk),
        .rst         (rst),
        .idle        (idle),
        .i_req       (i_req),
        .grant_i     (grant_i),
        .grant_d     (grant_d),
        .force_instr (force_instr)
    );

    // Arbitration FSM; every output is a register so mem_* never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_ack)
                        err <= 1'b1;
                    if (grant_i) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_wr    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                    end else if (grant_d) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_wr    <= d_wr;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end
                end
                BUSY_I: begin
                    if (mem_ack) begin
                        state   <= RESP_I;
                        mem_req <= 1'b0;
                        i_rdata <= mem_rdata;
                        i_ack   <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem_ack) begin
                        state   <= RESP_D;
                        mem_req <= 1'b0;
                        d_rdata <= mem_rdata;
                        d_ack   <= 1'b1;
                    end
                end
                RESP_I, RESP_D: begin
                    // A completion here has no owner: record it as a protocol error
                    if (mem_ack)
                        err <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple delayed-ack memory responder.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_ack;
    logic [XLEN-1:0] i_rdata;
    logic            d_req;
    logic            d_wr;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_ack;
    logic [XLEN-1:0] d_rdata;
    logic            mem_req;
    logic            mem_wr;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;
    logic            err;

    int total = 0;
    int bad   = 0;

    // memory responder: acks ack_delay cycles after mem_req rises
    int   ack_delay  = 0;
    int   wait_cnt   = 0;
    logic manual_ack = 1'b0;
    logic [XLEN-1:0] rdata_val = '0;

    assign mem_ack   = manual_ack || (mem_req && (wait_cnt == ack_delay));
    assign mem_rdata = rdata_val;

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output logic gi, output logic gd);
        gi = 1'b0;
        gd = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                gi = i_ack;
                gd = d_ack;
                return;
            end
        end
        chk("ack_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic gi, gd;
        int   acks;

        rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_wr",  {31'd0, mem_wr},  32'd0);
        chk("rst_i_ack",   {31'd0, i_ack},   32'd0);
        chk("rst_d_ack",   {31'd0, d_ack},   32'd0);
        chk("rst_err",     {31'd0, err},     32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_i_rdata",  i_rdata,  32'd0);
        chk("rst_d_rdata",  d_rdata,  32'd0);
        chk("rst_state",   {29'd0, dut.state}, {29'd0, IDLE});
        rst = 1'b0;
        @(negedge clk);

        // data read, mem_ack in cycle 3 -> d_ack in cycle 4
        ack_delay = 2; rdata_val = 32'hDEADBEEF;
        d_req = 1; d_wr = 0; d_addr = 32'h100;
        @(negedge clk);                                    // cycle 1
        chk("rd_mem_req_c1", {31'd0, mem_req}, 32'd1);
        chk("rd_mem_addr",   mem_addr, 32'h100);
        chk("rd_mem_wr",     {31'd0, mem_wr}, 32'd0);
        @(negedge clk);                                    // cycle 2
        chk("rd_no_ack_c2",  {31'd0, d_ack}, 32'd0);
        @(negedge clk);                                    // cycle 3
        chk("rd_memack_c3",  {31'd0, mem_ack}, 32'd1);
        chk("rd_no_ack_c3",  {31'd0, d_ack}, 32'd0);
        @(negedge clk);                                    // cycle 4
        chk("rd_ack_c4",     {31'd0, d_ack}, 32'd1);
        chk("rd_rdata_c4",   d_rdata, 32'hDEADBEEF);
        chk("rd_req_low_resp", {31'd0, mem_req}, 32'd0);
        d_req = 0;
        rdata_val = 32'h0;
        @(negedge clk);                                    // cycle 5
        chk("rd_ack_gone",   {31'd0, d_ack}, 32'd0);
        chk("rd_rdata_hold", d_rdata, 32'hDEADBEEF);
        chk("rd_idle",       {29'd0, dut.state}, {29'd0, IDLE});

        // both requesters held: order D,D,D,D,I,D
        ack_delay = 1; rdata_val = 32'h11110000;
        i_req = 1; i_addr = 32'h400; d_req = 1; d_wr = 1; d_addr = 32'h800; d_wdata = 32'h5;
        for (int k = 0; k < 6; k++) begin
            wait_ack(gi, gd);
            chk("order_i", {31'd0, gi}, (k == 4) ? 32'd1 : 32'd0);
            chk("order_d", {31'd0, gd}, (k == 4) ? 32'd0 : 32'd1);
            chk("order_addr", mem_addr, (k == 4) ? 32'h400 : 32'h800);
            chk("order_wr", {31'd0, mem_wr}, (k == 4) ? 32'd0 : 32'd1);
            chk("order_req_resp", {31'd0, mem_req}, 32'd0);
        end
        i_req = 0; d_req = 0; d_wr = 0;
        @(negedge clk);

        // data write held for three BUSY cycles, one ack
        ack_delay = 2;
        d_req = 1; d_wr = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("wr_mem_req",   {31'd0, mem_req}, 32'd1);
            chk("wr_mem_wr",    {31'd0, mem_wr},  32'd1);
            chk("wr_mem_wdata", mem_wdata, 32'h12345678);
            chk("wr_mem_addr",  mem_addr,  32'h20);
        end
        acks = 0;
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            if (d_ack) begin
                acks++;
                d_req = 0; d_wr = 0;
            end
        end
        chk("wr_one_ack", acks, 32'd1);

        // fetch held, mem_ack in same cycle as mem_req: ack every 3rd cycle
        ack_delay = 0; rdata_val = 32'h0BADF00D;
        i_req = 1; i_addr = 32'h1000;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk("fetch_ack_cadence", {31'd0, i_ack}, (c % 3 == 2) ? 32'd1 : 32'd0);
            if (i_ack) begin
                chk("fetch_req_in_resp", {31'd0, mem_req}, 32'd0);
                chk("fetch_rdata", i_rdata, 32'h0BADF00D);
                if (c == 8) i_req = 0;
            end
        end
        chk("fetch_err_clear", {31'd0, err}, 32'd0);

        // stray mem_ack while idle
        manual_ack = 1;
        @(negedge clk);
        manual_ack = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stray_err",   {31'd0, err},   32'd1);
            chk("stray_i_ack", {31'd0, i_ack}, 32'd0);
            chk("stray_d_ack", {31'd0, d_ack}, 32'd0);
        end

        // reset in the middle of a fetch
        ack_delay = 1000;
        i_req = 1; i_addr = 32'h2000;
        @(negedge clk);
        chk("abort_busy_req", {31'd0, mem_req}, 32'd1);
        #2 rst = 1;
        #1;
        chk("abort_req_drop", {31'd0, mem_req}, 32'd0);
        chk("abort_err_clr",  {31'd0, err},     32'd0);
        chk("abort_state",    {29'd0, dut.state}, {29'd0, IDLE});
        i_req = 0;
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_ack", {31'd0, i_ack},   32'd0);
            chk("abort_idle",   {29'd0, dut.state}, {29'd0, IDLE});
            chk("abort_no_req", {31'd0, mem_req}, 32'd0);
        end
        manual_ack = 1;
        @(negedge clk);
        manual_ack = 0;
        chk("late_ack_err", {31'd0, err}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, the number of consecutive data grants after which a waiting instruction request wins.
REQ-002 Port: clk  in  1  the single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: i_req  in  1  instruction-fetch read request; held until i_ack.
REQ-005 Port: i_addr  in  32  instruction address; stable while i_req is high.
REQ-006 Port: i_ack  out  1  one-cycle pulse; i_rdata is valid in that cycle.
REQ-007 Port: i_rdata  out  32  instruction read data.
REQ-008 Port: d_req  in  1  data request; held until d_ack.
REQ-009 Port: d_wr  in  1  data write=1, read=0; stable while d_req is high.
REQ-010 Port: d_addr  in  32  data address; stable while d_req is high.
REQ-011 Port: d_wdata  in  32  data write value; stable while d_req is high.
REQ-012 Port: d_ack  out  1  one-cycle completion pulse for reads and writes.
REQ-013 Port: d_rdata  out  32  data read value, valid with d_ack.
REQ-014 Port: mem_req  out  1  backing-memory request; held until mem_ack.
REQ-015 Port: mem_wr  out  1  backing-memory write enable.
REQ-016 Port: mem_addr  out  32  backing-memory address.
REQ-017 Port: mem_wdata  out  32  backing-memory write data.
REQ-018 Port: mem_rdata  in  32  backing-memory read data, valid with mem_ack.
REQ-019 Port: mem_ack  in  1  backing-memory completion pulse.
REQ-020 Port: err  out  1  sticky protocol-error flag.

Function
REQ-021 FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
REQ-022 In IDLE, only d_req: the next state is BUSY_D.
REQ-023 In IDLE, only i_req: the next state is BUSY_I.
REQ-024 In IDLE, both requests with starve_cnt < STARVE_LIMIT: data wins and the next state is BUSY_D.
REQ-025 In IDLE, both requests with starve_cnt == STARVE_LIMIT: instruction wins and the next state is BUSY_I.
REQ-026 On a grant, the winner's address, wr and wdata are registered; mem_* outputs are driven only from these registers. Instruction grants force mem_wr=0.
REQ-027 In BUSY_x, mem_req=1; on mem_ack, mem_rdata is captured into the response register and the next state is RESP_x.
REQ-028 In RESP_x, x_ack=1 and x_rdata equals the captured value; the next state is always IDLE.
REQ-029 mem_req is 0 in IDLE and RESP states, so each transaction has exactly one mem_req run.
REQ-030 Latency: request seen in IDLE at cycle 0 and mem_ack at cycle k (k>=1) gives x_ack at cycle k+1 and IDLE at cycle k+2. The minimum is 2 cycles.
REQ-031 A requester keeping req high after ack is treated as a new request in the following IDLE cycle.
REQ-032 i_rdata and d_rdata hold their last captured value outside ack cycles. d_rdata after a write is undefined-but-stable (the captured mem_rdata).
REQ-033 starve_cnt increments, saturating at STARVE_LIMIT, on each data grant while i_req=1.
REQ-034 starve_cnt clears on an instruction grant, and in IDLE when i_req=0.
REQ-035 mem_ack in IDLE or RESP states is ignored for data and sets err=1. err clears only on reset.

Reset
REQ-036 rst=1 asynchronously forces: state=IDLE, starve_cnt=0, err=0, mem_req=0, mem_wr=0, i_ack=0, d_ack=0, all address/data registers and rdata outputs=0.
REQ-037 Reset mid-transaction abandons it with no ack. A mem_ack arriving after rst deasserts while in IDLE sets err.

Structure
REQ-038 A shared package holds the state encoding (3-bit) and the width constant XLEN=32.
REQ-039 Sub-module arb_starve_counter holds starve_cnt and exposes a force_instr output (cnt==STARVE_LIMIT).

Verification
REQ-040 d_req=1 alone, d_addr=0x100, d_wr=0, mem_ack at cycle 3 with mem_rdata=0xDEADBEEF -> d_ack at cycle 4 with d_rdata=0xDEADBEEF, mem_addr=0x100.
REQ-041 i_req and d_req both held high, mem_ack 1 cycle after each mem_req -> grant order D,D,D,D,I,D… with STARVE_LIMIT=4.
REQ-042 d_wr=1, d_addr=0x20, d_wdata=0x12345678 -> mem_wr=1, mem_wdata=0x12345678 throughout BUSY_D; d_ack pulses once.
REQ-043 mem_ack pulsed while in IDLE -> err=1 and stays 1; no i_ack or d_ack is produced.
REQ-044 rst asserted during BUSY_I, mid-cycle -> mem_req falls immediately, no i_ack, state IDLE after release.
REQ-045 i_req held high across 3 transactions, mem_ack same cycle as mem_req -> i_ack every 3rd cycle, mem_req never high in RESP.
